// File: rtl/mem_tester_master_if.sv
// Avalon-MM master bus between the memory tester and the memory under test.
// The signal names carry the master's point of view in both modports.
interface mem_tester_master_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address_o;
  logic              write_o;
  logic [DATA_W-1:0] writedata_o;
  logic              read_o;
  logic [DATA_W-1:0] readdata_i;
  logic              readdatavalid_i;
  logic              waitrequest_i;

  modport master (
    output address_o, write_o, writedata_o, read_o,
    input  readdata_i, readdatavalid_i, waitrequest_i
  );

  modport slave (
    input  address_o, write_o, writedata_o, read_o,
    output readdata_i, readdatavalid_i, waitrequest_i
  );
endinterface

// File: rtl/mem_tester_master.sv
// Memory tester: writes an address-XOR-seed pattern over an inclusive address range,
// reads it back, and reports the mismatch count and the first failing address.
module mem_tester_master #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_start_i,
  input  logic [ADDR_W-1:0]   addr_end_i,
  input  logic [DATA_W-1:0]   seed_i,
  mem_tester_master_if.master avm,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] range_start_r, range_start_s;
  logic [ADDR_W-1:0] range_end_r, range_end_s;
  logic [DATA_W-1:0] seed_r, seed_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              write_r, write_s;
  logic              read_r, read_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [15:0]       err_cnt_r, err_cnt_s;
  logic [ADDR_W-1:0] first_err_r, first_err_s;
  logic [ADDR_W-1:0] addr_inc_s;

  // Test pattern: the address zero-extended or truncated to the data width, XOR the seed.
  function automatic logic [DATA_W-1:0] pattern_f(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] seed);
    return DATA_W'(addr) ^ seed;
  endfunction

  assign addr_inc_s = addr_r + ADDR_W'(1);

  // Next-state and next-output logic; every output is re-registered from these values.
  always_comb begin
    state_s       = state_r;
    addr_s        = addr_r;
    range_start_s = range_start_r;
    range_end_s   = range_end_r;
    seed_s        = seed_r;
    wdata_s       = wdata_r;
    err_cnt_s     = err_cnt_r;
    first_err_s   = first_err_r;
    pass_s        = pass_r;

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          range_start_s = addr_start_i;
          range_end_s   = addr_end_i;
          seed_s        = seed_i;
          err_cnt_s     = 16'd0;
          first_err_s   = '0;
          pass_s        = 1'b0;
          addr_s        = addr_start_i;
          wdata_s       = pattern_f(addr_start_i, seed_i);
          // An inverted range is reported as a failed test without touching memory.
          if (addr_end_i < addr_start_i) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WR: begin
        if (!avm.waitrequest_i) begin
          // Comparing before incrementing keeps the address from wrapping at all-ones.
          if (addr_r == range_end_r) begin
            state_s = ST_RD;
            addr_s  = range_start_r;
          end else begin
            addr_s  = addr_inc_s;
            wdata_s = pattern_f(addr_inc_s, seed_r);
          end
        end else begin
          state_s = ST_WR;
        end
      end

      ST_RD: begin
        if (!avm.waitrequest_i) begin
          state_s = ST_RD_WAIT;
        end else begin
          state_s = ST_RD;
        end
      end

      ST_RD_WAIT: begin
        if (avm.readdatavalid_i) begin
          if (avm.readdata_i != pattern_f(addr_r, seed_r)) begin
            if (err_cnt_r != 16'hFFFF) begin
              err_cnt_s = err_cnt_r + 16'd1;
            end else begin
              err_cnt_s = err_cnt_r;
            end
            if (err_cnt_r == 16'd0) begin
              first_err_s = addr_r;
            end else begin
              first_err_s = first_err_r;
            end
          end else begin
            err_cnt_s = err_cnt_r;
          end
          if (addr_r == range_end_r) begin
            state_s = ST_DONE;
            pass_s  = (err_cnt_s == 16'd0);
          end else begin
            state_s = ST_RD;
            addr_s  = addr_inc_s;
          end
        end else begin
          state_s = ST_RD_WAIT;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    write_s = (state_s == ST_WR);
    read_s  = (state_s == ST_RD);
    done_s  = (state_s == ST_DONE);
    busy_s  = (state_s == ST_WR) || (state_s == ST_RD) || (state_s == ST_RD_WAIT);
  end

  // State and registered-output update; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      range_start_r <= '0;
      range_end_r   <= '0;
      seed_r        <= '0;
      wdata_r       <= '0;
      write_r       <= 1'b0;
      read_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      err_cnt_r     <= 16'd0;
      first_err_r   <= '0;
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      range_start_r <= range_start_s;
      range_end_r   <= range_end_s;
      seed_r        <= seed_s;
      wdata_r       <= wdata_s;
      write_r       <= write_s;
      read_r        <= read_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      pass_r        <= pass_s;
      err_cnt_r     <= err_cnt_s;
      first_err_r   <= first_err_s;
    end
  end

  assign avm.address_o    = addr_r;
  assign avm.writedata_o  = wdata_r;
  assign avm.write_o      = write_r;
  assign avm.read_o       = read_r;
  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign pass_o           = pass_r;
  assign err_cnt_o        = err_cnt_r;
  assign first_err_addr_o = first_err_r;

endmodule
